psk_correlator_bank: RTL and testbench
======================================

Name: psk_correlator_bank

Overview:
- Multi-lag integrate-and-dump correlator for the 1-bit PSK receive path.
- Compares hard-sliced signal bits against N_LAGS delayed copies of the local code over a fixed window of qualified samples.
- At each window end, scans all lags for the peak, reports peak lag and value, and flags a match against a runtime threshold.
- Sits between the bit slicer and the acquisition/tracking controller.

Parameters:
- N_LAGS, 4, number of parallel lag channels; lag k compares sig against code delayed by k samples; >=1.
- WINDOW, 256, qualified samples per integration window; must be >= N_LAGS+3.
- ACC_W, $clog2(WINDOW+1), accumulator/value width; derived, not overridden.
- LAG_W, max(1,$clog2(N_LAGS)), lag index width; derived.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- en  in  1  sample qualifier; sig/code are sampled only when high.
- sig  in  1  sliced received bit.
- code  in  1  local code bit.
- start  in  1  synchronous resync: clears window, accumulators, delay line and scanner.
- threshold  in  ACC_W  match threshold; sampled at scan completion.
- dump_valid  out  1  one-cycle strobe: peak_* and match are updated.
- peak_lag  out  LAG_W  lag index of maximum accumulator.
- peak_value  out  ACC_W  maximum accumulator value.
- match  out  1  peak_value >= threshold; held with peak_* until the next dump.
- overrun  out  1  one-cycle pulse: a window ended while the scanner was busy.

Behaviour:
- Reset (rst low, async):
  - All accumulators, window counter, input stage, code delay line and snapshot registers are 0.
  - FSM is IDLE.
  - All outputs are 0.
- Input stage: on clk with en=1, sig_buf<=sig, code_buf<=code, en_d<=1; otherwise en_d<=0 and buffers hold.
- Delay line: code_dly[0]=code_buf; on en_d, code_dly[k]<=code_dly[k-1] for k=1..N_LAGS-1.
- Accumulate on en_d: acc[k] <= acc[k] + (sig_buf == code_dly[k]).
  - Max value is WINDOW, so ACC_W never overflows.
  - No saturation logic is needed.
- Window counter 0..WINDOW-1, advanced on en_d.
- Window end: en_d with count==WINDOW-1.
  - snap[k] <= acc[k] + current match bit.
  - acc[k] <= 0.
  - count <= 0.
  - The next sample starts a new window with no lost sample.
- Scanner FSM:
  - IDLE -> SCAN on window end.
  - SCAN: one lag per cycle, index 0..N_LAGS-1. best starts at snap[0], lag 0; lag i replaces best only if snap[i] > best (strictly greater), so the lowest lag wins ties.
  - SCAN -> REPORT after index N_LAGS-1.
  - REPORT: peak_lag, peak_value, match registered; dump_valid=1 for exactly one cycle; then -> IDLE.
- Latency: dump_valid is asserted N_LAGS+3 clk cycles after the edge that captured the final window sample into the input stage, independent of en.
- Window end while FSM not IDLE (only possible when WINDOW < N_LAGS+3, or via start misuse):
  - The new snapshot is dropped.
  - overrun pulses for one cycle.
  - The scan in progress completes unchanged.
- start=1 (synchronous, has priority over en):
  - acc, count, code_dly and snap are cleared.
  - FSM -> IDLE without dump_valid.
  - peak_*/match hold their last values.
  - A sample presented with en in the same cycle is discarded.
- rst mid-window or mid-scan: immediate clear per reset rule; no dump_valid for the interrupted window.
- start and window end in the same cycle: start wins; no scan, no overrun.

Decomposition:
- Shared package psk_pkg holds:
  - clog2-based width helper function.
  - FSM state enum (IDLE, SCAN, REPORT).
- One natural sub-module: psk_lag_acc, a single-lag accumulator with a clear/dump port, instantiated N_LAGS times via generate.
- Delay line, window counter and scanner stay in the top.

Test Plan (N_LAGS=4, WINDOW=16, threshold=12):
1. en=1 continuous, sig=code=PN15 sequence for 16 samples -> dump_valid once, 7 cycles after the last capture; peak_lag=0, peak_value=16, match=1, overrun=0.
2. sig = code delayed 2 samples (PN15), two windows -> second dump: peak_lag=2, peak_value=16, match=1.
3. code=1, sig=0 constant -> all snapshots 0; peak_lag=0 (tie rule), peak_value=0, match=0.
4. en toggling every other cycle, 16 qualified samples of test 1 over 32 cycles -> identical dump to test 1, exactly one dump_valid.
5. rst low at sample 9 of window, released, then 16 matching samples -> all outputs 0 during reset; next dump peak_value=16 counted from zero.
6. start pulsed 2 cycles after window end (during SCAN) -> no dump_valid for that window, peak_* hold the previous values; the next full window dumps normally.

Source files
------------

// File: rtl/psk_pkg.sv
// Shared types and width helpers for the PSK correlator bank.
package psk_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_REPORT
    } scan_state_t;

    // Index width that stays at least one bit wide, even for a single lag or window.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/psk_lag_acc.sv
// Single-lag integrate-and-dump accumulator with a snapshot register for the scanner.
module psk_lag_acc
#(
    parameter int ACC_W = 9
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_acc_en,
    input  logic             i_dump,
    input  logic             i_load,
    input  logic             i_hit,
    output logic [ACC_W-1:0] o_snap
);

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_snap;
    logic [ACC_W-1:0] w_sum;

    // The final sample of a window is folded into the snapshot, so no sample is lost.
    assign w_sum = r_acc + ACC_W'(i_hit);

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc  <= '0;
            r_snap <= '0;
        end else if (i_clr) begin
            r_acc  <= '0;
            r_snap <= '0;
        end else begin
            if (i_acc_en) begin
                r_acc <= i_dump ? '0 : w_sum;
            end
            if (i_load) begin
                r_snap <= w_sum;
            end
        end
    end

    assign o_snap = r_snap;

endmodule

// File: rtl/psk_correlator_bank.sv
// Multi-lag 1-bit correlator: per-lag integrate-and-dump plus a serial peak scanner.
module psk_correlator_bank
    import psk_pkg::*;
#(
    parameter int  N_LAGS = 4,
    parameter int  WINDOW = 256,
    localparam int ACC_W  = $clog2(WINDOW + 1),
    localparam int LAG_W  = clog2_min1(N_LAGS)
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig,
    input  logic             code,
    input  logic             start,
    input  logic [ACC_W-1:0] threshold,
    output logic             dump_valid,
    output logic [LAG_W-1:0] peak_lag,
    output logic [ACC_W-1:0] peak_value,
    output logic             match,
    output logic             overrun
);

    localparam int               CNT_W    = clog2_min1(WINDOW);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);
    localparam logic [LAG_W-1:0] IDX_LAST = LAG_W'(N_LAGS - 1);

    logic              r_sig_buf;
    logic              r_code_buf;
    logic              r_en_d;
    logic [CNT_W-1:0]  r_count;
    logic              r_dump_req;
    logic [LAG_W-1:0]  r_idx;
    logic [LAG_W-1:0]  r_best_lag;
    logic [ACC_W-1:0]  r_best_val;
    logic              r_dump_valid;
    logic [LAG_W-1:0]  r_peak_lag;
    logic [ACC_W-1:0]  r_peak_value;
    logic              r_match;
    logic              r_overrun;
    scan_state_t       r_state;
    scan_state_t       w_state_nxt;

    logic [N_LAGS-1:0] w_code_dly;
    logic [ACC_W-1:0]  w_snap [N_LAGS];
    logic              w_win_end;
    logic              w_busy;
    logic              w_load;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sig_buf  <= 1'b0;
            r_code_buf <= 1'b0;
            r_en_d     <= 1'b0;
        end else if (start) begin
            r_sig_buf  <= 1'b0;
            r_code_buf <= 1'b0;
            r_en_d     <= 1'b0;
        end else begin
            r_en_d <= en;
            if (en) begin
                r_sig_buf  <= sig;
                r_code_buf <= code;
            end
        end
    end

    assign w_code_dly[0] = r_code_buf;

    for (genvar k = 1; k < N_LAGS; k++) begin : g_dly
        logic r_d;
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_d <= 1'b0;
            end else if (start) begin
                r_d <= 1'b0;
            end else if (r_en_d) begin
                r_d <= w_code_dly[k-1];
            end
        end
        assign w_code_dly[k] = r_d;
    end

    assign w_win_end = r_en_d && (r_count == CNT_LAST);
    // A pending dump request counts as busy so a snapshot is never overwritten before it is scanned.
    assign w_busy    = (r_state != S_IDLE) || r_dump_req;
    assign w_load    = w_win_end && !w_busy && !start;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (start) begin
            r_count <= '0;
        end else if (r_en_d) begin
            r_count <= w_win_end ? '0 : r_count + CNT_W'(1);
        end
    end

    for (genvar k = 0; k < N_LAGS; k++) begin : g_lag
        psk_lag_acc #(.ACC_W(ACC_W)) u_acc (
            .clk      (clk),
            .rst      (rst),
            .i_clr    (start),
            .i_acc_en (r_en_d),
            .i_dump   (w_win_end),
            .i_load   (w_load),
            .i_hit    (r_sig_buf == w_code_dly[k]),
            .o_snap   (w_snap[k])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else if (start) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: the next-state default is assigned first so no path through the case infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (r_dump_req) w_state_nxt = S_SCAN;
            S_SCAN:   if (r_idx == IDX_LAST) w_state_nxt = S_REPORT;
            S_REPORT: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dump_req <= 1'b0;
            r_idx      <= '0;
            r_best_lag <= '0;
            r_best_val <= '0;
        end else if (start) begin
            r_dump_req <= 1'b0;
            r_idx      <= '0;
            r_best_lag <= '0;
            r_best_val <= '0;
        end else begin
            r_dump_req <= w_load;
            if (r_state == S_SCAN) begin
                // Strictly-greater replacement keeps the lowest lag on ties.
                if ((r_idx == '0) || (w_snap[r_idx] > r_best_val)) begin
                    r_best_val <= w_snap[r_idx];
                    r_best_lag <= r_idx;
                end
                r_idx <= r_idx + LAG_W'(1);
            end else begin
                r_idx <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dump_valid <= 1'b0;
            r_overrun    <= 1'b0;
            r_peak_lag   <= '0;
            r_peak_value <= '0;
            r_match      <= 1'b0;
        end else if (start) begin
            r_dump_valid <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_dump_valid <= (r_state == S_REPORT);
            r_overrun    <= w_win_end && w_busy;
            if (r_state == S_REPORT) begin
                r_peak_lag   <= r_best_lag;
                r_peak_value <= r_best_val;
                r_match      <= (r_best_val >= threshold);
            end
        end
    end

    assign dump_valid = r_dump_valid;
    assign peak_lag   = r_peak_lag;
    assign peak_value = r_peak_value;
    assign match      = r_match;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_psk_correlator_bank.sv
// Self-checking bench: directed scenarios plus random traffic against a window-level reference model.
module tb_psk_correlator_bank;

    localparam int N_LAGS = 4;
    localparam int WINDOW = 16;
    localparam int ACC_W  = 5;
    localparam int LAG_W  = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic             sig = 1'b0;
    logic             code = 1'b0;
    logic             start = 1'b0;
    logic [ACC_W-1:0] threshold = ACC_W'(12);
    logic             dump_valid;
    logic [LAG_W-1:0] peak_lag;
    logic [ACC_W-1:0] peak_value;
    logic             match;
    logic             overrun;

    psk_correlator_bank #(.N_LAGS(N_LAGS), .WINDOW(WINDOW)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .sig        (sig),
        .code       (code),
        .start      (start),
        .threshold  (threshold),
        .dump_valid (dump_valid),
        .peak_lag   (peak_lag),
        .peak_value (peak_value),
        .match      (match),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int last_cap = 0;
    int n_dumps  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: every qualified sample since the last clear, scored per window.
    typedef struct {
        int due;
        int lag;
        int val;
    } dump_t;

    bit    sig_h[$];
    bit    code_h[$];
    dump_t pend[$];
    int    exp_dv;
    int    exp_lag;
    int    exp_val;
    int    exp_match;

    function automatic dump_t score_last_window(input int due);
        dump_t d;
        int    n0;
        d.due = due;
        d.lag = 0;
        d.val = -1;
        n0 = sig_h.size() - WINDOW;
        for (int k = 0; k < N_LAGS; k++) begin
            int sc = 0;
            for (int n = n0; n < n0 + WINDOW; n++) begin
                bit cd = (n >= k) ? code_h[n-k] : 1'b0;
                if (sig_h[n] == cd) sc++;
            end
            if (sc > d.val) begin
                d.val = sc;
                d.lag = k;
            end
        end
        return d;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            sig_h.delete();
            code_h.delete();
            pend.delete();
            exp_dv = 0; exp_lag = 0; exp_val = 0; exp_match = 0;
        end else if (start) begin
            sig_h.delete();
            code_h.delete();
            pend.delete();
            exp_dv = 0;
        end else begin
            exp_dv = 0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                exp_dv    = 1;
                exp_lag   = pend[0].lag;
                exp_val   = pend[0].val;
                exp_match = (pend[0].val >= int'(threshold)) ? 1 : 0;
                void'(pend.pop_front());
            end
            if (en) begin
                sig_h.push_back(sig);
                code_h.push_back(code);
                if (sig_h.size() % WINDOW == 0) pend.push_back(score_last_window(cyc + N_LAGS + 3));
            end
        end
    end

    always @(negedge clk) begin
        if (dump_valid) n_dumps++;
        if (!rst) begin
            check("rst_dump_valid", int'(dump_valid), 0);
            check("rst_peak_lag", int'(peak_lag), 0);
            check("rst_peak_value", int'(peak_value), 0);
            check("rst_match", int'(match), 0);
            check("rst_overrun", int'(overrun), 0);
        end else begin
            check("dump_valid", int'(dump_valid), exp_dv);
            check("peak_lag", int'(peak_lag), exp_lag);
            check("peak_value", int'(peak_value), exp_val);
            check("match", int'(match), exp_match);
            check("overrun", int'(overrun), 0);
        end
    end

    task automatic step(input bit e, input bit s, input bit c, input bit st);
        en = e; sig = s; code = c; start = st;
        @(posedge clk);
        #1;
        if (e && !st) last_cap = cyc;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wait_dump(output int lat);
        bit seen;
        seen = 1'b0;
        lat  = -1;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (dump_valid) begin
                seen = 1'b1;
                lat  = cyc - last_cap;
            end
        end
        if (!seen) check("dump_timeout", 0, 1);
    endtask

    bit pn [64];

    initial begin
        logic [3:0] l;
        int lat;
        int d0;
        l = 4'b0001;
        for (int i = 0; i < 64; i++) begin
            pn[i] = l[3];
            l = {l[2:0], l[3] ^ l[2]};
        end

        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_peak_value", int'(peak_value), 0);
        check("reset_dump_valid", int'(dump_valid), 0);
        rst = 1'b1;
        idle(2);

        // 1: perfect alignment, lag 0 wins with a full window.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int n = 0; n < WINDOW; n++) step(1'b1, pn[n], pn[n], 1'b0);
        idle(1);
        wait_dump(lat);
        check("t1_latency", lat, 7);
        check("t1_peak_lag", int'(peak_lag), 0);
        check("t1_peak_value", int'(peak_value), 16);
        check("t1_match", int'(match), 1);
        idle(4);

        // 2: sig is code delayed by two samples; second window peaks at lag 2.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int n = 0; n < 2 * WINDOW; n++) step(1'b1, (n >= 2) ? pn[n-2] : 1'b0, pn[n], 1'b0);
        idle(1);
        wait_dump(lat);
        check("t2_latency", lat, 7);
        check("t2_peak_lag", int'(peak_lag), 2);
        check("t2_peak_value", int'(peak_value), 16);
        check("t2_match", int'(match), 1);
        idle(4);

        // 3: no agreement on any lag once the delay line is full of ones; tie goes to lag 0.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int n = 0; n < 2 * WINDOW; n++) step(1'b1, 1'b0, 1'b1, 1'b0);
        idle(1);
        wait_dump(lat);
        check("t3_peak_lag", int'(peak_lag), 0);
        check("t3_peak_value", int'(peak_value), 0);
        check("t3_match", int'(match), 0);
        idle(4);

        // 4: qualifier toggling every other cycle gives the same dump as test 1.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        d0 = n_dumps;
        for (int n = 0; n < WINDOW; n++) begin
            step(1'b1, pn[n], pn[n], 1'b0);
            step(1'b0, pn[n], pn[n], 1'b0);
        end
        wait_dump(lat);
        check("t4_latency", lat, 7);
        check("t4_peak_value", int'(peak_value), 16);
        check("t4_peak_lag", int'(peak_lag), 0);
        idle(10);
        check("t4_dump_count", n_dumps - d0, 1);

        // 5: asynchronous reset mid-window, then a clean window from zero.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int n = 0; n < 9; n++) step(1'b1, pn[n], pn[n], 1'b0);
        en  = 1'b0;
        rst = 1'b0;
        #1;
        check("t5_rst_peak_value", int'(peak_value), 0);
        idle(3);
        rst = 1'b1;
        for (int n = 0; n < WINDOW; n++) step(1'b1, pn[n+3], pn[n+3], 1'b0);
        idle(1);
        wait_dump(lat);
        check("t5_latency", lat, 7);
        check("t5_peak_value", int'(peak_value), 16);
        check("t5_match", int'(match), 1);
        idle(4);

        // 6: start during SCAN aborts the dump and leaves peak outputs untouched.
        for (int n = 0; n < WINDOW; n++) step(1'b1, ~pn[n], pn[n], 1'b0);
        idle(2);
        d0 = n_dumps;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        idle(12);
        check("t6_no_dump", n_dumps - d0, 0);
        check("t6_hold_value", int'(peak_value), 16);
        check("t6_hold_lag", int'(peak_lag), 0);
        for (int n = 0; n < WINDOW; n++) step(1'b1, (n >= 3) ? pn[n-3] : 1'b0, pn[n], 1'b0);
        idle(1);
        wait_dump(lat);
        check("t6_peak_lag", int'(peak_lag), 3);
        check("t6_peak_value", int'(peak_value), 16);

        // Random traffic: sparse qualifier, occasional resync and threshold changes.
        for (int i = 0; i < 1500; i++) begin
            bit c;
            bit s;
            c = 1'($urandom_range(0, 1));
            s = ($urandom_range(0, 2) != 0) ? c : 1'($urandom_range(0, 1));
            if ($urandom_range(0, 99) == 0) threshold = ACC_W'($urandom_range(0, 16));
            step(($urandom_range(0, 9) < 7), s, c, ($urandom_range(0, 199) == 0));
        end
        idle(20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
